sdram_multiport_arbiter: RTL

Single-clock SDRAM burst scheduler that multiplexes NUM_WRITERS write streams and NUM_READERS read streams onto one burst SDRAM controller command interface (command / data_address / data_write / data_read / data_read_valid / data_write_done). It generalises the single-camera/single-display scheduler: N channels per direction, round-robin within each direction, selectable read-priority or alternating direction policy, per-channel frame regions and frame-restart inputs. Clock-domain-crossing FIFOs sit outside this block, on its sdram_clk side.

---
 rtl/sdram_multiport_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sdram_multiport_arbiter.sv
// Burst scheduler: multiplexes NUM_WRITERS write streams and NUM_READERS read
// streams onto a single burst SDRAM controller command interface. Each channel
// owns a frame region; bursts walk through it and wrap at the region end.
module sdram_multiport_arbiter #(
    parameter int NUM_WRITERS   = 2,
    parameter int NUM_READERS   = 2,
    parameter int BURST_LENGTH  = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 22,
    parameter int REGION_WORDS  = 153600,
    parameter int READ_PRIORITY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_WRITERS-1:0]            wr_ready,
    input  logic [NUM_WRITERS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WRITERS-1:0]            wr_ack,
    input  logic [NUM_WRITERS-1:0]            wr_restart,
    input  logic [NUM_READERS-1:0]            rd_ready,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [NUM_READERS-1:0]            rd_valid,
    input  logic [NUM_READERS-1:0]            rd_restart,
    output logic [1:0]                        command,
    output logic [ADDR_WIDTH-1:0]             data_address,
    output logic [DATA_WIDTH-1:0]             data_write,
    input  logic [DATA_WIDTH-1:0]             data_read,
    input  logic                              data_read_valid,
    input  logic                              data_write_done
);

    localparam int WIW = (NUM_WRITERS > 1) ? $clog2(NUM_WRITERS) : 1;
    localparam int RIW = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
    localparam int BW  = $clog2(BURST_LENGTH);

    // Encoding doubles as the controller command code.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIW-1:0]  wr_grant;     // also the round-robin "last granted" pointer
    logic [RIW-1:0]  rd_grant;
    logic            last_wr;      // direction of the most recent burst
    logic [BW-1:0]   beat;
    logic [ADDR_WIDTH-1:0] wr_off [NUM_WRITERS];
    logic [ADDR_WIDTH-1:0] rd_off [NUM_READERS];
    logic [NUM_WRITERS-1:0] wr_pend;
    logic [NUM_READERS-1:0] rd_pend;

    logic go_rd, go_wr, beat_evt, burst_end;
    int   wr_pick, rd_pick;

    // First requester after 'last' in circular order; 'last' if none request.
    function automatic int rr_pick(input logic [7:0] req, input int last, input int n);
        int pick;
        pick = last;
        for (int k = n; k >= 1; k--) begin
            if (req[(last + k) % n]) pick = (last + k) % n;
        end
        return pick;
    endfunction

    // Direction choice, channel choice and next state.
    always_comb begin
        go_rd     = 1'b0;
        go_wr     = 1'b0;
        state_nxt = state;
        wr_pick   = rr_pick(8'(wr_ready), int'(wr_grant), NUM_WRITERS);
        rd_pick   = rr_pick(8'(rd_ready), int'(rd_grant), NUM_READERS);
        beat_evt  = (state == ST_WRITE && data_write_done) ||
                    (state == ST_READ  && data_read_valid);
        burst_end = beat_evt && (beat == BW'(BURST_LENGTH - 1));
        if (|rd_ready && |wr_ready) begin
            if (READ_PRIORITY != 0) go_rd = 1'b1;
            else begin
                go_rd = last_wr;
                go_wr = !last_wr;
            end
        end else begin
            go_rd = |rd_ready;
            go_wr = |wr_ready;
        end
        case (state)
            ST_IDLE:  state_nxt = go_rd ? ST_READ : (go_wr ? ST_WRITE : ST_IDLE);
            ST_WRITE,
            ST_READ:  if (burst_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, grants, beat counter, per-channel offsets and restart flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wr_grant <= WIW'(NUM_WRITERS - 1);
            rd_grant <= RIW'(NUM_READERS - 1);
            last_wr  <= 1'b1;
            beat     <= '0;
            wr_pend  <= '0;
            rd_pend  <= '0;
            for (int i = 0; i < NUM_WRITERS; i++) wr_off[i] <= '0;
            for (int j = 0; j < NUM_READERS; j++) rd_off[j] <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                beat <= '0;
                if (go_rd) begin
                    rd_grant <= RIW'(rd_pick);
                    last_wr  <= 1'b0;
                end else if (go_wr) begin
                    wr_grant <= WIW'(wr_pick);
                    last_wr  <= 1'b1;
                end
            end else if (beat_evt) begin
                beat <= burst_end ? '0 : beat + 1'b1;
            end
            // A restart on an active channel is deferred to burst completion.
            for (int i = 0; i < NUM_WRITERS; i++) begin
                if (state == ST_WRITE && int'(wr_grant) == i) begin
                    if (burst_end) begin
                        wr_pend[i] <= 1'b0;
                        if (wr_pend[i] || wr_restart[i]) wr_off[i] <= '0;
                        else if (wr_off[i] + ADDR_WIDTH'(BURST_LENGTH) == ADDR_WIDTH'(REGION_WORDS))
                            wr_off[i] <= '0;
                        else wr_off[i] <= wr_off[i] + ADDR_WIDTH'(BURST_LENGTH);
                    end else begin
                        wr_pend[i] <= wr_pend[i] | wr_restart[i];
                    end
                end else if (wr_pend[i] || wr_restart[i]) begin
                    wr_off[i]  <= '0;
                    wr_pend[i] <= 1'b0;
                end
            end
            for (int j = 0; j < NUM_READERS; j++) begin
                if (state == ST_READ && int'(rd_grant) == j) begin
                    if (burst_end) begin
                        rd_pend[j] <= 1'b0;
                        if (rd_pend[j] || rd_restart[j]) rd_off[j] <= '0;
                        else if (rd_off[j] + ADDR_WIDTH'(BURST_LENGTH) == ADDR_WIDTH'(REGION_WORDS))
                            rd_off[j] <= '0;
                        else rd_off[j] <= rd_off[j] + ADDR_WIDTH'(BURST_LENGTH);
                    end else begin
                        rd_pend[j] <= rd_pend[j] | rd_restart[j];
                    end
                end else if (rd_pend[j] || rd_restart[j]) begin
                    rd_off[j]  <= '0;
                    rd_pend[j] <= 1'b0;
                end
            end
        end
    end

    assign command = state;
    assign rd_data = data_read;

    // Controller-side address/data and per-channel FIFO strobes.
    always_comb begin
        data_address = '0;
        data_write   = '0;
        wr_ack       = '0;
        rd_valid     = '0;
        if (state == ST_WRITE) begin
            data_address = ADDR_WIDTH'(int'(wr_grant) * REGION_WORDS) + wr_off[wr_grant];
            data_write   = wr_data[int'(wr_grant)*DATA_WIDTH +: DATA_WIDTH];
            wr_ack[wr_grant] = data_write_done;
        end else if (state == ST_READ) begin
            data_address = ADDR_WIDTH'(int'(rd_grant) * REGION_WORDS) + rd_off[rd_grant];
            rd_valid[rd_grant] = data_read_valid;
        end
    end

endmodule
